// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg
//   Shared constants and helpers for the GPIO input conditioner.
//   - BTN_*            : button index order within btn_* vectors (u, l, d, r, c)
//   - DEBOUNCE_DEFAULT : default stable-cycle count before a new level is accepted
//   - cnt_width()      : width of a debounce counter that must hold 0..cycles
package gpio_in_pkg;

   localparam int unsigned BTN_U = 0;
   localparam int unsigned BTN_L = 1;
   localparam int unsigned BTN_D = 2;
   localparam int unsigned BTN_R = 3;
   localparam int unsigned BTN_C = 4;

   localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit
//   One input bit: 2-FF synchroniser followed by a counter-based debouncer.
//   The stable level only moves after DEBOUNCE_CYCLES consecutive cycles of the
//   synchronised input disagreeing with it; any return to the stable level
//   restarts the count.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   raw_i   - raw asynchronous pin
//   level_o - debounced level
//   rise_o  - registered 1-cycle pulse, asserted the cycle level_o goes 0->1
//   fall_o  - registered 1-cycle pulse, asserted the cycle level_o goes 1->0
module gpio_debounce_bit
   import gpio_in_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync_q;
   logic            s;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign s = sync_q[1];

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s != level_q) begin
         if (cnt_q == CntMax) begin
            // Disagreement has lasted DEBOUNCE_CYCLES cycles: accept it.
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
//   Synchronises and debounces the board push-buttons and DIP switches and
//   derives press/release pulses, sticky per-button event flags, a switch
//   change pulse and (optionally) per-button press counters.
//   Optional feature macro: GPIO_PRESS_COUNT_EN enables the 8-bit press
//   counters; without it btn_cnt_o is tied to 0 and cnt_clr_i is ignored.
// Ports:
//   clk_i         - system clock
//   rst_ni        - asynchronous active-low reset
//   btn_raw_i     - raw button pins (u, l, d, r, c)
//   sw_raw_i      - raw switch pins
//   btn_level_o   - debounced button levels
//   sw_level_o    - debounced switch levels
//   btn_press_o   - 1-cycle pulse on debounced 0->1
//   btn_release_o - 1-cycle pulse on debounced 1->0
//   btn_evt_o     - sticky press flags
//   evt_clr_i     - per-bit clear of btn_evt_o (level or pulse)
//   sw_chg_o      - 1-cycle pulse when any debounced switch bit changes
//   btn_cnt_o     - press counters, button i at [8i+7:8i]
//   cnt_clr_i     - clears all press counters
module gpio_input_conditioner
   import gpio_in_pkg::*;
#(
   parameter int unsigned N_BTN           = 5,
   parameter int unsigned N_SW            = 8,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_BTN-1:0]   btn_raw_i,
   input  logic [N_SW-1:0]    sw_raw_i,
   output logic [N_BTN-1:0]   btn_level_o,
   output logic [N_SW-1:0]    sw_level_o,
   output logic [N_BTN-1:0]   btn_press_o,
   output logic [N_BTN-1:0]   btn_release_o,
   output logic [N_BTN-1:0]   btn_evt_o,
   input  logic [N_BTN-1:0]   evt_clr_i,
   output logic               sw_chg_o,
   output logic [8*N_BTN-1:0] btn_cnt_o,
   input  logic               cnt_clr_i
);

   logic [N_SW-1:0]  sw_rise, sw_fall;
   logic [N_BTN-1:0] evt_q, evt_d;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      gpio_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .raw_i  (btn_raw_i[i]),
         .level_o(btn_level_o[i]),
         .rise_o (btn_press_o[i]),
         .fall_o (btn_release_o[i])
      );
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      gpio_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .raw_i  (sw_raw_i[i]),
         .level_o(sw_level_o[i]),
         .rise_o (sw_rise[i]),
         .fall_o (sw_fall[i])
      );
   end

   // Rise/fall are registered on the level-update edge, so this pulse lines up
   // with the sw_level_o change.
   assign sw_chg_o = |(sw_rise | sw_fall);

   // Set has priority over clear so a press is never lost to a racing clear.
   always_comb begin
      evt_d = (evt_q & ~evt_clr_i) | btn_press_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         evt_q <= '0;
      end else begin
         evt_q <= evt_d;
      end
   end

   assign btn_evt_o = evt_q;

`ifdef GPIO_PRESS_COUNT_EN
   logic [N_BTN-1:0][7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < N_BTN; i++) begin
         if (cnt_clr_i) begin
            cnt_d[i] = 8'h00;
         end else if (btn_press_o[i]) begin
            cnt_d[i] = cnt_q[i] + 8'h01;  // wraps 255 -> 0
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign btn_cnt_o = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr_i;
   assign btn_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner
//   Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES = 4.
//   Inputs are driven and outputs sampled on the falling clock edge. Edge
//   counts below include the rising edge that first samples a new raw value,
//   so a held level updates on the 6th edge (2 sync + 4 debounce).
//   Honours GPIO_PRESS_COUNT_EN to select the counter checks.
module tb_gpio_input_conditioner;

  localparam int unsigned NB = 5;
  localparam int unsigned NS = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NB-1:0]   btn_raw, btn_level, btn_press, btn_release, btn_evt, evt_clr;
  logic [NS-1:0]   sw_raw, sw_level;
  logic            sw_chg, cnt_clr;
  logic [8*NB-1:0] btn_cnt;

  int checks  = 0;
  int errors  = 0;
  int chg_cnt = 0;

  always #5 clk = ~clk;

  gpio_input_conditioner #(
    .N_BTN          (NB),
    .N_SW           (NS),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstn),
    .btn_raw_i    (btn_raw),
    .sw_raw_i     (sw_raw),
    .btn_level_o  (btn_level),
    .sw_level_o   (sw_level),
    .btn_press_o  (btn_press),
    .btn_release_o(btn_release),
    .btn_evt_o    (btn_evt),
    .evt_clr_i    (evt_clr),
    .sw_chg_o     (sw_chg),
    .btn_cnt_o    (btn_cnt),
    .cnt_clr_i    (cnt_clr)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      chg_cnt += int'(sw_chg);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    btn_raw = 5'b00001;
    sw_raw  = '0;
    evt_clr = '0;
    cnt_clr = 1'b0;

    // Reset with button u held.
    tick(2);
    chk("rst_btn_level", btn_level, 5'b00000);
    chk("rst_sw_level", sw_level, 8'h00);
    chk("rst_press", btn_press, 5'b00000);
    chk("rst_release", btn_release, 5'b00000);
    chk("rst_evt", btn_evt, 5'b00000);
    chk("rst_sw_chg", sw_chg, 1'b0);
    chk("rst_cnt", btn_cnt, 40'h0);

    rstn = 1'b1;
    tick(5);
    chk("held_level_edge5", btn_level, 5'b00000);
    tick(1);
    chk("held_level_edge6", btn_level, 5'b00001);
    chk("held_press", btn_press, 5'b00001);
    tick(1);
    chk("held_press_1cyc", btn_press, 5'b00000);
    chk("held_evt", btn_evt, 5'b00001);

    btn_raw = 5'b00000;
    tick(5);
    chk("u_rel_early", btn_release, 5'b00000);
    tick(1);
    chk("u_release", btn_release, 5'b00001);
    chk("u_level_low", btn_level, 5'b00000);
    evt_clr = 5'b00001;
    tick(1);
    evt_clr = 5'b00000;
    chk("u_evt_clr", btn_evt, 5'b00000);

    // Glitch of 3 cycles on button d is rejected.
    btn_raw[2] = 1'b1;
    tick(3);
    btn_raw[2] = 1'b0;
    tick(10);
    chk("glitch_level", btn_level, 5'b00000);
    chk("glitch_evt", btn_evt, 5'b00000);

    // 4 cycles is accepted; release 6 edges after the raw fall.
    btn_raw[2] = 1'b1;
    tick(4);
    btn_raw[2] = 1'b0;
    tick(1);
    chk("d4_level_early", btn_level, 5'b00000);
    tick(1);
    chk("d4_level", btn_level, 5'b00100);
    chk("d4_press", btn_press, 5'b00100);
    tick(3);
    chk("d4_rel_early", btn_release, 5'b00000);
    tick(1);
    chk("d4_release", btn_release, 5'b00100);
    chk("d4_level_low", btn_level, 5'b00000);
    evt_clr = 5'b00100;
    tick(1);
    evt_clr = 5'b00000;

    // Bouncing switch 7: 1,0,1,0,1 then held high.
    chg_cnt = 0;
    sw_raw[7] = 1'b1; tick(1);
    sw_raw[7] = 1'b0; tick(1);
    sw_raw[7] = 1'b1; tick(1);
    sw_raw[7] = 1'b0; tick(1);
    sw_raw[7] = 1'b1; tick(1);
    tick(4);
    chk("bounce_level_early", sw_level, 8'h00);
    tick(1);
    chk("bounce_level", sw_level, 8'h80);
    chk("bounce_chg", sw_chg, 1'b1);
    tick(5);
    chk("bounce_chg_count", chg_cnt, 1);

    // Sticky flag vs clear race on button c.
    btn_raw[4] = 1'b1;
    tick(6);
    chk("c_press", btn_press, 5'b10000);
    tick(1);
    chk("c_evt", btn_evt, 5'b10000);
    btn_raw[4] = 1'b0;
    tick(6);
    chk("c_release", btn_release, 5'b10000);
    btn_raw[4] = 1'b1;
    tick(6);
    chk("c_press2", btn_press, 5'b10000);
    evt_clr = 5'b10000;
    tick(1);
    evt_clr = 5'b00000;
    chk("c_race_set_wins", btn_evt, 5'b10000);
    evt_clr = 5'b10000;
    tick(1);
    evt_clr = 5'b00000;
    chk("c_clr", btn_evt, 5'b00000);
    btn_raw[4] = 1'b0;
    tick(8);

    // Reset mid-count on button l (counter at 2).
    btn_raw[1] = 1'b1;
    tick(4);
    rstn = 1'b0;
    #1;
    chk("midrst_btn_level", btn_level, 5'b00000);
    chk("midrst_sw_level", sw_level, 8'h00);
    tick(1);
    rstn = 1'b1;
    tick(5);
    chk("midrst_level_early", btn_level, 5'b00000);
    tick(1);
    chk("midrst_level", btn_level, 5'b00010);
    chk("midrst_sw_level_back", sw_level, 8'h80);
    chk("midrst_sw_chg", sw_chg, 1'b1);
    btn_raw = '0;
    sw_raw  = '0;
    tick(8);

`ifdef GPIO_PRESS_COUNT_EN
    chk("cnt_l_counted", btn_cnt, 40'h00_00_00_01_00);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("cnt_clr", btn_cnt, 40'h0);
    for (int k = 0; k < 257; k++) begin
      btn_raw[3] = 1'b1;
      tick(6);
      btn_raw[3] = 1'b0;
      tick(6);
    end
    chk("cnt_wrap_257", btn_cnt, 40'h00_01_00_00_00);
    btn_raw[3] = 1'b1;
    tick(6);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", btn_cnt, 40'h0);
    btn_raw[3] = 1'b0;
    tick(6);
`else
    chk("cnt_tied_after_presses", btn_cnt, 40'h0);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    btn_raw[3] = 1'b1;
    tick(7);
    chk("cnt_tied_r_press", btn_cnt, 40'h0);
    chk("r_level", btn_level, 5'b01000);
    btn_raw[3] = 1'b0;
    tick(6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
